// File: rtl/rsa_modexp.sv
// Modular exponentiation engine: result = base^exponent mod modulus using
// right-to-left square-and-multiply over two bit-serial interleaved multipliers.
module rsa_modexp #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW = WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MUL    = 2'd1,
    UPDATE = 2'd2
  } state_t;

  state_t           state_r, next_state_s;
  logic [WIDTH-1:0] e_r, n_r, b_r, m_r, r_r, result_r;
  logic [PW-1:0]    pr_r, ps_r, pr_next_s, ps_next_s;
  logic [WIDTH-1:0] r_new_s;
  logic [IW-1:0]    i_r, cnt_r;
  logic             ready_r, done_r;
  logic             accept_s, short_s, mul_last_s, last_bit_s;

  // One interleaved step: P <- 2P + (bit ? op : 0), then up to two conditional subtractions of N.
  function automatic logic [PW-1:0] mm_step(input logic [PW-1:0] p, input logic bit_v,
                                            input logic [WIDTH-1:0] op, input logic [WIDTH-1:0] n);
    logic [PW-1:0] t;
    logic [PW-1:0] nn;
    nn = {2'b00, n};
    t  = (p << 1) + (bit_v ? {2'b00, op} : {PW{1'b0}});
    t  = (t >= nn) ? (t - nn) : t;
    t  = (t >= nn) ? (t - nn) : t;
    return t;
  endfunction

  // Next-state decode and control strobes.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    short_s      = 1'b0;
    mul_last_s   = (cnt_r == IW'(WIDTH - 1));
    last_bit_s   = (i_r == IW'(WIDTH - 1));
    case (state_r)
      IDLE: begin
        if (start) begin
          if (~|modulus[WIDTH-1:1]) begin
            short_s = 1'b1;
          end else begin
            accept_s     = 1'b1;
            next_state_s = MUL;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      MUL: begin
        if (mul_last_s) begin
          next_state_s = UPDATE;
        end else begin
          next_state_s = MUL;
        end
      end
      UPDATE: begin
        if (last_bit_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = MUL;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Both multipliers consume the same multiplier bit (MSB of the shifted copy of B).
  always_comb begin
    pr_next_s = mm_step(pr_r, m_r[WIDTH-1], r_r, n_r);
    ps_next_s = mm_step(ps_r, m_r[WIDTH-1], b_r, n_r);
    r_new_s   = e_r[i_r] ? pr_r[WIDTH-1:0] : r_r;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_r      <= {WIDTH{1'b0}};
      n_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      m_r      <= {WIDTH{1'b0}};
      r_r      <= {WIDTH{1'b0}};
      result_r <= {WIDTH{1'b0}};
      pr_r     <= {PW{1'b0}};
      ps_r     <= {PW{1'b0}};
      i_r      <= {IW{1'b0}};
      cnt_r    <= {IW{1'b0}};
      ready_r  <= 1'b1;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (short_s) begin
            result_r <= {WIDTH{1'b0}};
            done_r   <= 1'b1;
          end else if (accept_s) begin
            e_r     <= exponent;
            n_r     <= modulus;
            b_r     <= base;
            m_r     <= base;
            r_r     <= {{(WIDTH-1){1'b0}}, 1'b1};
            i_r     <= {IW{1'b0}};
            cnt_r   <= {IW{1'b0}};
            pr_r    <= {PW{1'b0}};
            ps_r    <= {PW{1'b0}};
            ready_r <= 1'b0;
          end
        end
        MUL: begin
          pr_r  <= pr_next_s;
          ps_r  <= ps_next_s;
          m_r   <= {m_r[WIDTH-2:0], 1'b0};
          cnt_r <= mul_last_s ? {IW{1'b0}} : (cnt_r + IW'(1));
        end
        UPDATE: begin
          r_r  <= r_new_s;
          b_r  <= ps_r[WIDTH-1:0];
          m_r  <= ps_r[WIDTH-1:0];
          pr_r <= {PW{1'b0}};
          ps_r <= {PW{1'b0}};
          if (last_bit_s) begin
            result_r <= r_new_s;
            done_r   <= 1'b1;
            ready_r  <= 1'b1;
          end else begin
            i_r <= i_r + IW'(1);
          end
        end
        default: begin
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign ready  = ready_r;
  assign done   = done_r;
  assign result = result_r;

endmodule

// File: tb/tb_rsa_modexp.sv
// Scoreboard bench for rsa_modexp: 16-bit directed/random operations against a
// repeated-multiplication reference, plus one 256-bit Fermat check.
module tb_rsa_modexp;

  localparam int unsigned LAT16  = 272;
  localparam int unsigned LAT256 = 65792;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        start16 = 1'b0;
  logic [15:0] base16 = 16'd0, exp16 = 16'd0, mod16 = 16'd0, result16;
  logic        ready16, done16;

  logic         start256 = 1'b0;
  logic [255:0] base256 = 256'd0, exp256 = 256'd0, mod256 = 256'd0, result256;
  logic         ready256, done256;

  rsa_modexp #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .base(base16), .exponent(exp16),
    .modulus(mod16), .ready(ready16), .done(done16), .result(result16));

  rsa_modexp #(.WIDTH(256)) dut256 (
    .clk(clk), .reset(reset), .start(start256), .base(base256), .exponent(exp256),
    .modulus(mod256), .ready(ready256), .done(done256), .result(result256));

  typedef struct { logic [15:0] res; int unsigned cyc; } exp16_t;
  typedef struct { logic [255:0] res; int unsigned cyc; } exp256_t;
  exp16_t  q16[$];
  exp256_t q256[$];

  int unsigned cyc = 0;
  int total = 0;
  int bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: multiply by base e times, reducing each time.
  function automatic logic [15:0] ref_modexp(input int unsigned b, input int unsigned e, input int unsigned n);
    longint unsigned r;
    if (n < 2) return 16'd0;
    r = 1;
    for (int unsigned j = 0; j < e; j++) r = (r * longint'(b)) % longint'(n);
    return 16'(r);
  endfunction

  // Monitor for the 16-bit engine.
  always @(negedge clk) begin
    if (!reset && done16) begin
      if (q16.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done16: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        exp16_t x;
        x = q16.pop_front();
        chk("result16", result16, x.res);
        chk("done_cycle16", cyc, x.cyc);
        chk("ready_at_done16", ready16, 1);
      end
    end
  end

  // Monitor for the 256-bit engine.
  always @(negedge clk) begin
    if (!reset && done256) begin
      if (q256.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done256: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        exp256_t y;
        y = q256.pop_front();
        chk("result256", result256, y.res);
        chk("done_cycle256", cyc, y.cyc);
      end
    end
  end

  task automatic issue16(input logic [15:0] b, input logic [15:0] e, input logic [15:0] n,
                         output int unsigned k);
    exp16_t x;
    int w;
    w = 0;
    @(negedge clk);
    while (!ready16 && w < 1000) begin @(negedge clk); w++; end
    if (!ready16) begin
      total++; bad++;
      $display("FAIL ready_wait16: got ready=0 expected ready=1 within budget");
    end
    base16 = b; exp16 = e; mod16 = n; start16 = 1'b1;
    @(posedge clk); #1;
    k = cyc;
    start16 = 1'b0;
    base16 = 16'($urandom); exp16 = 16'($urandom); mod16 = 16'($urandom);
    x.res = ref_modexp(b, e, n);
    x.cyc = k + ((n < 16'd2) ? 0 : LAT16);
    q16.push_back(x);
  endtask

  task automatic wait_idle16(input int budget);
    int w;
    w = 0;
    while (q16.size() != 0 && w < budget) begin @(negedge clk); w++; end
    if (q16.size() != 0) begin
      total++; bad++;
      $display("FAIL timeout16: got %0d pending ops expected 0", q16.size());
      q16.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int unsigned k, k2;
    logic [15:0] rb, re, rn;
    logic [255:0] p;
    exp256_t y;
    int w;

    repeat (3) @(negedge clk);
    chk("reset_ready16", ready16, 1);
    chk("reset_done16", done16, 0);
    chk("reset_result16", result16, 0);
    chk("reset_ready256", ready256, 1);
    reset = 1'b0;

    // Textbook case.
    issue16(16'd4, 16'd13, 16'd497, k);
    @(negedge clk);
    chk("ready_busy16", ready16, 0);
    wait_idle16(400);
    chk("result_held16", result16, 16'd445);

    // RSA round trip, decrypt started in the done cycle of the encrypt.
    issue16(16'd65, 16'd17, 16'd3233, k);
    issue16(16'd2790, 16'd2753, 16'd3233, k2);
    chk("back_to_back_accept", k2, k + LAT16 + 1);
    wait_idle16(400);

    // Edge operands.
    issue16(16'd7, 16'd0, 16'd13, k);
    wait_idle16(400);
    issue16(16'd9, 16'd5, 16'd1, k);
    wait_idle16(10);
    chk("short_ready16", ready16, 1);
    issue16(16'd0, 16'd3, 16'd0, k);
    wait_idle16(10);

    // Ignored start mid-operation.
    issue16(16'd4, 16'd13, 16'd497, k);
    while (cyc < k + 100) @(negedge clk);
    chk("ready_mid16", ready16, 0);
    base16 = 16'd3; exp16 = 16'd5; mod16 = 16'd7; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    wait_idle16(400);

    // Reset mid-operation.
    issue16(16'd4, 16'd13, 16'd497, k);
    while (cyc < k + 150) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midreset_ready16", ready16, 1);
    chk("midreset_done16", done16, 0);
    chk("midreset_result16", result16, 0);
    q16.delete();
    @(negedge clk);
    reset = 1'b0;
    issue16(16'd4, 16'd13, 16'd497, k);
    wait_idle16(400);

    // Random operands.
    for (int t = 0; t < 8; t++) begin
      rn = 16'($urandom_range(65535, 2));
      rb = 16'($urandom % rn);
      re = 16'($urandom_range(65535, 0));
      issue16(rb, re, rn, k);
    end
    wait_idle16(400);

    // Fermat check at full width: 2^(p-1) mod p = 1 for p = 2^255-19.
    p = 256'd1 << 255;
    @(negedge clk);
    base256 = 256'd2; exp256 = p - 256'd20; mod256 = p - 256'd19; start256 = 1'b1;
    @(posedge clk); #1;
    k = cyc;
    start256 = 1'b0;
    base256 = 256'd0; exp256 = 256'd0; mod256 = 256'd0;
    y.res = 256'd1;
    y.cyc = k + LAT256;
    q256.push_back(y);
    w = 0;
    while (q256.size() != 0 && w < 70000) begin @(negedge clk); w++; end
    if (q256.size() != 0) begin
      total++; bad++;
      $display("FAIL timeout256: got %0d pending ops expected 0", q256.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rsa_modexp.md
# rsa_modexp

Modular exponentiation engine for the RSA datapath. It computes result = base^exponent mod modulus on WIDTH-bit operands using right-to-left binary square-and-multiply over a bit-serial interleaved modular multiplier. It sits directly downstream of the byte-addressed RSA operand register file: it consumes the base, exponent and modulus registers in parallel, and its result is written back as the output operand.

## Interface
- WIDTH, 256, operand width in bits (must be ≥ 4)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only on an edge where ready=1
- base  input  WIDTH  multiplicand; must be < modulus
- exponent  input  WIDTH  exponent
- modulus  input  WIDTH  modulus N
- ready  output  1  engine idle, able to accept start
- done  output  1  one-cycle pulse: result valid
- result  output  WIDTH  base^exponent mod modulus; held until the next accepted start

## Operation
- The clock is named clk. Reset is named reset, is asynchronous, and is active-high. This is fixed.
- Reset values: ready=1, done=0, result=0, state=IDLE, and all internal registers are 0.
- State machine states are IDLE, MUL and UPDATE.
- **IDLE:** on start=1 the engine latches exponent (E), modulus (N) and base (B), sets R=1 and bit index i=0, then goes to MUL. Inputs may change freely after acceptance.
- **Short path:** if modulus < 2 at acceptance, the engine sets result=0, pulses done and stays in IDLE.
- **MUL (WIDTH cycles):** two interleaved multipliers run in parallel. Both share the multiplier bits of B, taken MSB first.
  - The accumulator PR computes R·B mod N.
  - The accumulator PS computes B·B mod N.
  - Each cycle, for each accumulator: P ← 2P + (bit ? operand : 0), then subtract N while P ≥ N (at most twice, combinational).
  - Accumulators are WIDTH+2 bits wide and are cleared on entry to MUL.
- **UPDATE (1 cycle):**
  - If E[i]=1, then R ← PR. B ← PS always.
  - If i = WIDTH−1: result ← R (new value), done pulse, go to IDLE. Otherwise i ← i+1 and go to MUL.
- **Fixed latency:** all exponent bits are processed regardless of their value. There is no early exit.
- **start while ready=0:** ignored with no effect, including while done=1 is not yet asserted.
- **exponent = 0:** result = 1 (modulus ≥ 2).
- **base ≥ modulus:** result unspecified. done still asserts with normal latency, and the engine must not hang.
- **reset mid-operation:** the engine returns immediately to reset values. The partial result is discarded and result reads 0.

## Timing
- Start is accepted on edge k. ready is 0 from after edge k until after edge k + WIDTH·(WIDTH+1).
- done=1 and result are valid in the cycle following edge k + WIDTH·(WIDTH+1). At the same edge ready returns to 1.
- For WIDTH=256 the latency is 65792 cycles. For WIDTH=16 it is 272 cycles.
- Short path: done=1 and result=0 in the cycle after edge k, and ready stays 1 throughout.
- A start asserted in the same cycle as done is accepted (back-to-back operation).
- done is exactly one cycle wide. result changes only at a done edge or on reset.

## Test plan
- **WIDTH=16, textbook case:** base=4, exponent=13, modulus=497 → result=445 and done exactly 272 cycles after acceptance.
- **WIDTH=16, RSA round trip:**
  - Encrypt: base=65, exponent=17, modulus=3233 → 2790.
  - Then start back-to-back in the done cycle with base=2790, exponent=2753, modulus=3233 → 65.
- **WIDTH=16, edge operands:**
  - base=7, exponent=0, modulus=13 → 1 after 272 cycles.
  - modulus=1 → result=0 with done one cycle after acceptance and ready never dropping.
- **WIDTH=16, disturbances:**
  - Pulse start at cycle 100 of an operation → ignored, and the original result still arrives at cycle 272.
  - Assert reset at cycle 150 → ready=1, done=0 and result=0 immediately. A subsequent 4^13 mod 497 returns 445.
- **WIDTH=256, Fermat check:** base=2, exponent=2^255−20, modulus=2^255−19 → result=1 and done after 65792 cycles.
